// File: rtl/mul32_share_sched.sv
// Round-robin scheduler that shares one pipelined 32x32 multiplier among NREQ requesters.
// Results return in issue order through a credit-protected first-word-fall-through FIFO.
module mul32_share_sched #(
  parameter int NREQ       = 4,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*32-1:0]        req_a,
  input  logic [NREQ*32-1:0]        req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic [63:0]               mul_i_msg,
  input  logic [31:0]               mul_lo,
  input  logic [31:0]               mul_hi,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic [31:0]               resp_lo,
  output logic [31:0]               resp_hi,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int EW  = IDW + 64;

  logic [IDW-1:0]   ptr_q, ptr_d, grant_id;
  logic [IDW:0]     arb_idx;
  logic             grant_vld, issue, can_issue, capture, push, pop;
  logic [CW-1:0]    infl_q, infl_d, fcnt_q, fcnt_d;
  logic [63:0]      msg_q, msg_d;
  logic [LATENCY-1:0] tag_vld_q;
  logic [IDW-1:0]   tag_id_q [LATENCY];
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [EW-1:0]    head;
  logic [AW-1:0]    wr_q, rd_q;

  // Registered counts only: a pop in this cycle frees its credit next cycle.
  assign can_issue = ({1'b0, infl_q} + {1'b0, fcnt_q}) < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    arb_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (arb_idx >= (IDW+1)'(NREQ)) arb_idx = arb_idx - (IDW+1)'(NREQ);
      if (can_issue && !grant_vld && req_valid[arb_idx[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = arb_idx[IDW-1:0];
      end
    end
    req_ready = '0;
    if (grant_vld) req_ready[grant_id] = 1'b1;
  end

  assign issue   = grant_vld;
  assign capture = tag_vld_q[LATENCY-1];
  assign push    = capture;
  assign pop     = resp_valid & resp_ready;

  always_comb begin
    ptr_d = ptr_q;
    msg_d = msg_q;
    if (issue) begin
      ptr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
      msg_d = {req_b[32*grant_id +: 32], req_a[32*grant_id +: 32]};
    end
    infl_d = infl_q + CW'(issue) - CW'(capture);
    fcnt_d = fcnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q     <= '0;
      msg_q     <= '0;
      tag_vld_q <= '0;
      infl_q    <= '0;
      fcnt_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
    end else begin
      ptr_q        <= ptr_d;
      msg_q        <= msg_d;
      infl_q       <= infl_d;
      fcnt_q       <= fcnt_d;
      tag_vld_q[0] <= issue;
      for (int i = 1; i < LATENCY; i++) tag_vld_q[i] <= tag_vld_q[i-1];
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Tag IDs and FIFO payload are qualified by valid bits/counts, so they need no reset.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= grant_id;
    for (int i = 1; i < LATENCY; i++) tag_id_q[i] <= tag_id_q[i-1];
    if (push) mem_q[wr_q] <= {tag_id_q[LATENCY-1], mul_hi, mul_lo};
  end

  assign head       = mem_q[rd_q];
  assign resp_valid = (fcnt_q != '0);
  assign resp_id    = resp_valid ? head[EW-1:64] : '0;
  assign resp_hi    = resp_valid ? head[63:32]   : '0;
  assign resp_lo    = resp_valid ? head[31:0]    : '0;
  assign mul_i_msg  = msg_q;
  assign busy       = (infl_q != '0) | (fcnt_q != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && fcnt_q == CW'(FIFO_DEPTH)));

endmodule
